// File: rtl/mmu_bus_arbiter.sv
// mmu_bus_arbiter
// Shares one physical memory port between the translated instruction and data
// paths. Data normally wins arbitration; instruction fetch is forced through
// after STARVE_LIMIT consecutive data grants made while a fetch was waiting.
// Requests carrying an MMU exception complete locally without a bus cycle.
// Optional feature: define MMU_ARB_TIMEOUT_EN to add a bus watchdog and the
// bus_err output; the default build has neither.
module mmu_bus_arbiter #(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   input  logic        inst_exp,
   output logic        inst_ack,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [3:0]  data_be,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic        data_exp,
   output logic        data_ack,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
`ifdef MMU_ARB_TIMEOUT_EN
   output logic        bus_err,
`endif
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, BUSY_D, BUSY_I, LOCAL_D, LOCAL_I} state_t;

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   state_t        state, state_nxt;
   logic [SW-1:0] starve_cnt, starve_nxt;
   logic          grant_d, grant_i;
   logic          load_d, load_i;
   logic          bus_to;

   // A fetch request held opposite a saturated starvation count beats data.
   assign grant_d = (state == IDLE) && data_req && !(inst_req && starve_cnt == STARVE_MAX);
   assign grant_i = (state == IDLE) && !grant_d && inst_req;
   assign load_d  = grant_d && !data_exp;
   assign load_i  = grant_i && !inst_exp;
   assign mem_req = (state == BUSY_D) || (state == BUSY_I);

`ifdef MMU_ARB_TIMEOUT_EN
   localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int TW     = (TW_RAW > 8) ? TW_RAW : 8;
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

   logic [TW-1:0] to_cnt;

   // Watchdog: restarts at each bus grant and counts every cycle spent waiting for mem_ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (load_d || load_i) begin
         to_cnt <= '0;
      end else if (mem_req) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign bus_to  = mem_req && !mem_ack && (to_cnt == TO_MAX);
   assign bus_err = bus_to;
`else
   assign bus_to = 1'b0;
`endif

   // State and starvation counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   // Bus command capture at grant; held stable for the whole bus transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (load_d) begin
         mem_we    <= data_we;
         mem_be    <= data_be;
         mem_addr  <= data_addr;
         mem_wdata <= data_wdata;
      end else if (load_i) begin
         mem_we    <= 1'b0;
         mem_be    <= 4'hF;
         mem_addr  <= inst_addr;
         mem_wdata <= '0;
      end
   end

   // Next-state, starvation tracking and completion pulses.
   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
      inst_ack   = 1'b0;
      data_ack   = 1'b0;
      inst_rdata = '0;
      data_rdata = '0;
      unique case (state)
         IDLE: begin
            if (grant_d) begin
               state_nxt = data_exp ? LOCAL_D : BUSY_D;
            end else if (grant_i) begin
               state_nxt = inst_exp ? LOCAL_I : BUSY_I;
            end
            if (grant_i || !inst_req) begin
               starve_nxt = '0;
            end else if (grant_d && starve_cnt != STARVE_MAX) begin
               starve_nxt = starve_cnt + 1'b1;
            end
         end
         BUSY_D: begin
            if (mem_ack || bus_to) begin
               data_ack   = 1'b1;
               data_rdata = mem_ack ? mem_rdata : 32'h0;
               state_nxt  = IDLE;
            end
         end
         BUSY_I: begin
            if (mem_ack || bus_to) begin
               inst_ack   = 1'b1;
               inst_rdata = mem_ack ? mem_rdata : 32'h0;
               state_nxt  = IDLE;
            end
         end
         LOCAL_D: begin
            data_ack  = 1'b1;
            state_nxt = IDLE;
         end
         LOCAL_I: begin
            inst_ack  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// tb_mmu_bus_arbiter
// Randomized and directed stimulus for mmu_bus_arbiter, checked each cycle
// against a transaction-level reference model. With MMU_ARB_TIMEOUT_EN defined
// the watchdog is exercised with TIMEOUT_CYCLES = 8.
module tb_mmu_bus_arbiter;

   localparam int SL = 4;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_exp, inst_ack;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_we, data_exp, data_ack;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MMU_ARB_TIMEOUT_EN
   logic        bus_err;
`endif

   always #5 clk = ~clk;

   mmu_bus_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_exp(inst_exp),
      .inst_ack(inst_ack), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_we(data_we), .data_be(data_be),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_exp(data_exp),
      .data_ack(data_ack), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
`ifdef MMU_ARB_TIMEOUT_EN
      .bus_err(bus_err),
`endif
      .mem_rdata(mem_rdata)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: at most one outstanding transaction, plus the number of
   // data grants given in a row while a fetch was waiting.
   bit          t_live, t_inst, t_local;
   logic        t_we;
   logic [3:0]  t_be;
   logic [31:0] t_addr, t_wdata;
   int          t_wait;
   int          run_d;
   bit          done_i, done_d;
   logic [31:0] go;
   int          n_go;

   task automatic model_reset();
      t_live = 0;
      run_d  = 0;
      done_i = 0;
      done_d = 0;
   endtask

   // Called just after a rising edge with inputs already driven. Checks the
   // outputs mid-cycle, then advances the model at the next rising edge.
   task automatic tick();
      bit          fin, e_req, e_err, e_ia, e_da, pick_d, pick_i;
      logic [31:0] e_rd;
      #4;
      fin = 0; e_req = 0; e_err = 0; e_rd = '0;
      if (t_live) begin
         if (t_local) begin
            fin = 1;
         end else begin
            e_req = 1;
            if (mem_ack) begin
               fin  = 1;
               e_rd = mem_rdata;
            end
`ifdef MMU_ARB_TIMEOUT_EN
            else if (t_wait == TO) begin
               fin   = 1;
               e_err = 1;
            end
`endif
         end
      end
      e_ia = fin && t_inst;
      e_da = fin && !t_inst;
      chk("inst_ack", inst_ack, e_ia);
      chk("data_ack", data_ack, e_da);
      chk("mem_req", mem_req, e_req);
      if (e_ia) chk("inst_rdata", inst_rdata, e_rd);
      if (e_da) chk("data_rdata", data_rdata, e_rd);
      if (e_req) begin
         chk("mem_addr", mem_addr, t_addr);
         chk("mem_we", mem_we, t_we);
         if (!t_inst) begin
            chk("mem_be", mem_be, t_be);
            chk("mem_wdata", mem_wdata, t_wdata);
         end
      end
`ifdef MMU_ARB_TIMEOUT_EN
      chk("bus_err", bus_err, e_err);
`endif
      if (data_ack) begin go = {go[30:0], 1'b0}; n_go++; end
      if (inst_ack) begin go = {go[30:0], 1'b1}; n_go++; end
      done_i = e_ia;
      done_d = e_da;
      @(posedge clk);
      if (t_live) begin
         if (fin) t_live = 0;
         else     t_wait++;
      end else begin
         pick_d = data_req && !(inst_req && run_d == SL);
         pick_i = !pick_d && inst_req;
         if (pick_i || !inst_req) run_d = 0;
         else if (pick_d)         run_d = (run_d < SL) ? run_d + 1 : SL;
         if (pick_d) begin
            t_live = 1; t_inst = 0; t_local = data_exp; t_wait = 0;
            t_we = data_we; t_be = data_be; t_addr = data_addr; t_wdata = data_wdata;
         end else if (pick_i) begin
            t_live = 1; t_inst = 1; t_local = inst_exp; t_wait = 0;
            t_we = 1'b0; t_be = 4'hF; t_addr = inst_addr; t_wdata = '0;
         end
      end
      #1;
   endtask

   task automatic quiet();
      inst_req = 0; inst_exp = 0; inst_addr = '0;
      data_req = 0; data_exp = 0; data_we = 0; data_be = '0;
      data_addr = '0; data_wdata = '0;
      mem_ack = 0; mem_rdata = '0;
   endtask

   initial begin
      rst = 1'b1;
      quiet();
      model_reset();
      go = '0; n_go = 0;
      #12;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_inst_ack", inst_ack, 1'b0);
      chk("rst_data_ack", data_ack, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_be", mem_be, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      tick();

      // Plain read, acked on the third bus cycle.
      data_req = 1; data_addr = 32'h0000_1000; data_we = 0; data_be = 4'hF;
      tick(); tick(); tick();
      mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      chk("read_done", data_ack, 1'b0);
      quiet();
      tick();

      // Data request with an MMU exception completes locally.
      data_req = 1; data_exp = 1; data_addr = 32'h0000_2000;
      tick();
      tick();
      quiet();
      tick();

      // Write with payload churn while the bus cycle is pending.
      data_req = 1; data_we = 1; data_be = 4'b0011;
      data_addr = 32'h0000_3000; data_wdata = 32'h1234_5678;
      tick();
      for (int i = 0; i < 3; i++) begin
         data_we = 0; data_be = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
         tick();
      end
      mem_ack = 1; mem_rdata = $urandom;
      tick();
      quiet();
      tick(); tick();

      // Both paths saturated with immediate acks: fetch forced every fifth grant.
      go = '0; n_go = 0;
      inst_req = 1; inst_addr = 32'h0000_8000; data_req = 1; data_addr = 32'h0000_4000;
      mem_ack = 1;
      for (int i = 0; i < 20; i++) begin
         mem_rdata = $urandom;
         tick();
      end
      chk("starve_count", n_go, 10);
      chk("starve_order", go[9:0], 10'b0000100001);
      quiet();
      tick(); tick();

      // Reset while a fetch owns the bus.
      inst_req = 1; inst_addr = 32'h0000_9000;
      tick(); tick();
      #1 rst = 1'b1;
      #1;
      chk("rst_busy_mem_req", mem_req, 1'b0);
      chk("rst_busy_inst_ack", inst_ack, 1'b0);
      model_reset();
      rst = 1'b0;
      tick(); tick();
      chk("post_rst_mem_req", mem_req, 1'b1);
      mem_ack = 1; mem_rdata = 32'hCAFE_0001;
      tick();
      quiet();
      tick();

      // Randomized traffic, including exceptions, dropped requests and stray acks.
      for (int c = 0; c < 3000; c++) begin
         if (!inst_req || done_i) inst_req = ($urandom_range(2) == 0);
         else if ($urandom_range(24) == 0) inst_req = 0;
         if (!data_req || done_d) data_req = ($urandom_range(2) == 0);
         else if ($urandom_range(24) == 0) data_req = 0;
         inst_exp   = ($urandom_range(4) == 0);
         data_exp   = ($urandom_range(4) == 0);
         inst_addr  = $urandom;
         data_addr  = $urandom;
         data_wdata = $urandom;
         data_we    = 1'($urandom);
         data_be    = 4'($urandom);
         mem_ack    = ($urandom_range(2) == 0);
         mem_rdata  = $urandom;
         tick();
      end
      quiet();
      tick(); tick(); tick();

`ifdef MMU_ARB_TIMEOUT_EN
      // Bus never answers: watchdog completes the request.
      data_req = 1; data_addr = 32'h0000_5000;
      for (int i = 0; i < 12; i++) begin
         if (done_d) data_req = 0;
         tick();
      end
      quiet();
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
